brq_lsu_split: RTL

Load/store unit between the ID/EX stage and the data bus. It feeds the writeback stage with load data, write enable and response/error status.
- Accepts one access at a time from ID/EX.
- Drives a request/grant/rvalid data-bus handshake.
- Splits misaligned accesses into two word transactions.
- Returns aligned, sign- or zero-extended load data.

---
 rtl/brq_lsu_split.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/brq_lsu_split.sv
// brq_lsu_split: load/store unit driving a req/gnt/rvalid data bus, one access at a time.
// BRQ_LSU_MISALIGNED_EN splits misaligned accesses in two; otherwise they complete with an error.
module brq_lsu_split #(
    parameter int DataWidth = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 lsu_req_i,
    input  logic                 lsu_we_i,
    input  logic [1:0]           lsu_type_i,
    input  logic                 lsu_sign_ext_i,
    input  logic [31:0]          lsu_addr_i,
    input  logic [DataWidth-1:0] lsu_wdata_i,
    output logic                 lsu_ready_o,
    output logic                 lsu_busy_o,
    output logic                 data_req_o,
    input  logic                 data_gnt_i,
    output logic [31:0]          data_addr_o,
    output logic                 data_we_o,
    output logic [3:0]           data_be_o,
    output logic [DataWidth-1:0] data_wdata_o,
    input  logic                 data_rvalid_i,
    input  logic                 data_err_i,
    input  logic [DataWidth-1:0] data_rdata_i,
    output logic [DataWidth-1:0] lsu_rdata_o,
    output logic                 lsu_rdata_we_o,
    output logic                 lsu_resp_valid_o,
    output logic                 lsu_resp_err_o,
    output logic [31:0]          lsu_addr_last_o
);
    typedef enum logic [2:0] {
        IDLE,
        WAIT_GNT,
        WAIT_RVALID,
`ifdef BRQ_LSU_MISALIGNED_EN
        WAIT_GNT_2,
        WAIT_RVALID_2
`else
        ERR
`endif
    } state_e;

    state_e                 state_q, state_d;
    logic [31:0]            addr_q, addr_last_q, cur_addr;
    logic [1:0]             type_q, cur_type, off;
    logic                   sign_q, we_q, misal_q;
    logic [DataWidth-1:0]   wdata_q, rdata_q, cur_wdata, rdata1, ext;
    logic [2*DataWidth-1:0] wrot, raw;
    logic [3:0]             base_mask;
    logic [7:0]             be8;
    logic                   idle, accept, misal_in, gnt2, rv2, second, fin, err_st;

`ifdef BRQ_LSU_MISALIGNED_EN
    localparam bit SplitEn = 1'b1;
    assign gnt2   = state_q == WAIT_GNT_2;
    assign rv2    = state_q == WAIT_RVALID_2;
    assign err_st = 1'b0;
`else
    localparam bit SplitEn = 1'b0;
    assign gnt2   = 1'b0;
    assign rv2    = 1'b0;
    assign err_st = state_q == ERR;
`endif

    // In IDLE the bus fields come straight from ID/EX so the request goes out in the accept cycle
    assign idle      = state_q == IDLE;
    assign accept    = idle && lsu_req_i;
    assign second    = gnt2 || rv2;
    assign cur_addr  = idle ? lsu_addr_i : addr_q;
    assign cur_type  = idle ? lsu_type_i : type_q;
    assign cur_wdata = idle ? lsu_wdata_i : wdata_q;
    assign off       = cur_addr[1:0];
    assign base_mask = cur_type == 2'b10 ? 4'b0001 : cur_type == 2'b01 ? 4'b0011 : 4'b1111;
    assign be8       = {4'b0000, base_mask} << off;
    assign misal_in  = |be8[7:4];
    assign wrot      = {cur_wdata, cur_wdata} << {off, 3'b000};

    assign lsu_ready_o  = idle;
    assign lsu_busy_o   = !idle;
    assign data_req_o   = (accept && (SplitEn || !misal_in)) || state_q == WAIT_GNT || gnt2;
    assign data_addr_o  = {cur_addr[31:2], 2'b00} + (second ? 32'd4 : 32'd0);
    assign data_be_o    = second ? be8[7:4] : be8[3:0];
    assign data_we_o    = idle ? lsu_we_i : we_q;
    assign data_wdata_o = wrot[2*DataWidth-1:DataWidth];

    assign fin    = data_rvalid_i && ((state_q == WAIT_RVALID && (data_err_i || !misal_q)) || rv2);
    assign rdata1 = rv2 ? rdata_q : data_rdata_i;
    assign raw    = {data_rdata_i, rdata1} >> {off, 3'b000};
    assign ext    = type_q == 2'b10 ? {{24{sign_q && raw[7]}}, raw[7:0]} :
                    type_q == 2'b01 ? {{16{sign_q && raw[15]}}, raw[15:0]} : raw[DataWidth-1:0];

    assign lsu_resp_valid_o = fin || err_st;
    assign lsu_resp_err_o   = (fin && data_err_i) || err_st;
    assign lsu_rdata_we_o   = fin && !data_err_i && !we_q;
    assign lsu_rdata_o      = lsu_rdata_we_o ? ext : '0;
    assign lsu_addr_last_o  = addr_last_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:          if (lsu_req_i) state_d = data_gnt_i ? WAIT_RVALID : WAIT_GNT;
            WAIT_GNT:      if (data_gnt_i) state_d = WAIT_RVALID;
`ifdef BRQ_LSU_MISALIGNED_EN
            WAIT_RVALID:   if (data_rvalid_i) state_d = fin ? IDLE : WAIT_GNT_2;
            WAIT_GNT_2:    if (data_gnt_i) state_d = WAIT_RVALID_2;
            WAIT_RVALID_2: if (data_rvalid_i) state_d = IDLE;
`else
            WAIT_RVALID:   if (data_rvalid_i) state_d = IDLE;
`endif
            default:       state_d = IDLE;
        endcase
`ifndef BRQ_LSU_MISALIGNED_EN
        if (accept && misal_in) state_d = ERR;
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            type_q      <= '0;
            sign_q      <= 1'b0;
            we_q        <= 1'b0;
            misal_q     <= 1'b0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            addr_last_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q  <= lsu_addr_i;
                type_q  <= lsu_type_i;
                sign_q  <= lsu_sign_ext_i;
                we_q    <= lsu_we_i;
                misal_q <= misal_in;
                wdata_q <= lsu_wdata_i;
            end
            if (state_q == WAIT_RVALID && data_rvalid_i) rdata_q <= data_rdata_i;
            if (data_req_o && data_gnt_i) addr_last_q <= data_addr_o;
            else if (accept && misal_in && !SplitEn) addr_last_q <= lsu_addr_i;
        end
    end
endmodule
